tdm_demux12: RTL



---
 rtl/tdm_demux12.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tdm_demux12.sv
// Receive side of the 2:1 TDM link: splits alternating A/B slots into two held
// channels, tracks frame lock and keeps a saturating protocol-error count.
module tdm_demux12 #(
   parameter int WIDTH   = 1,
   parameter int TIMEOUT = 15,
   parameter int ERRW    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic             a_valid,
   output logic             b_valid,
   output logic             pair_valid,
   output logic             locked,
   output logic             sync_err,
   output logic [ERRW-1:0]  err_cnt
);

   localparam int IDW = $clog2(TIMEOUT + 1);
   localparam logic [IDW-1:0] IDLE_LAST = IDW'(TIMEOUT - 1);

   typedef enum logic [1:0] {HUNT, EXP_B, EXP_A} state_t;

   state_t           r_state, w_state;
   logic [IDW-1:0]   r_idle, w_idle;
   logic [WIDTH-1:0] r_a, w_a;
   logic [WIDTH-1:0] r_b, w_b;
   logic             r_av, w_av;
   logic             r_bv, w_bv;
   logic             r_pv, w_pv;
   logic             r_lock, w_lock;
   logic             r_err, w_err;
   logic [ERRW-1:0]  r_cnt, w_cnt;

   function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= HUNT;
         r_idle  <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_av    <= 1'b0;
         r_bv    <= 1'b0;
         r_pv    <= 1'b0;
         r_lock  <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state;
         r_idle  <= w_idle;
         r_a     <= w_a;
         r_b     <= w_b;
         r_av    <= w_av;
         r_bv    <= w_bv;
         r_pv    <= w_pv;
         r_lock  <= w_lock;
         r_err   <= w_err;
         r_cnt   <= w_cnt;
      end
   end

   always_comb begin
      w_state = r_state;
      w_idle  = r_idle;
      w_a     = r_a;
      w_b     = r_b;
      w_av    = 1'b0;
      w_bv    = 1'b0;
      w_pv    = 1'b0;
      w_lock  = r_lock;
      w_err   = 1'b0;
      w_cnt   = r_cnt;
      unique case (r_state)
         HUNT: begin
            if (din_valid && sync) begin
               w_a     = din;
               w_av    = 1'b1;
               w_idle  = '0;
               w_state = EXP_B;
            end
         end
         EXP_B: begin
            if (din_valid) begin
               w_idle = '0;
               if (!sync) begin
                  w_b     = din;
                  w_bv    = 1'b1;
                  w_pv    = 1'b1;
                  w_lock  = 1'b1;
                  w_state = EXP_A;
               end else begin
                  // B slot missing: resynchronise on the new A without dropping lock
                  w_a   = din;
                  w_av  = 1'b1;
                  w_err = 1'b1;
                  w_cnt = sat_inc(r_cnt);
               end
            end else if (r_idle == IDLE_LAST) begin
               w_idle  = '0;
               w_err   = 1'b1;
               w_cnt   = sat_inc(r_cnt);
               w_lock  = 1'b0;
               w_state = HUNT;
            end else begin
               w_idle = r_idle + 1'b1;
            end
         end
         EXP_A: begin
            if (din_valid) begin
               if (sync) begin
                  w_a     = din;
                  w_av    = 1'b1;
                  w_idle  = '0;
                  w_state = EXP_B;
               end else begin
                  w_err   = 1'b1;
                  w_cnt   = sat_inc(r_cnt);
                  w_lock  = 1'b0;
                  w_state = HUNT;
               end
            end
         end
         default: w_state = HUNT;
      endcase
   end

   assign a_out      = r_a;
   assign b_out      = r_b;
   assign a_valid    = r_av;
   assign b_valid    = r_bv;
   assign pair_valid = r_pv;
   assign locked     = r_lock;
   assign sync_err   = r_err;
   assign err_cnt    = r_cnt;

endmodule
